// File: rtl/modulo_display_contador_7_bits_pkg.sv
// Shared encodings for the counter display: FSM states, 7-segment patterns, BCD helper.
package modulo_display_contador_7_bits_pkg;

  localparam int unsigned BIN_W     = 7;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned BCD_W     = 12;
  localparam int unsigned SEG_W     = 7;
  localparam int unsigned DIG_N     = 3;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } conv_state_t;

  // Three-digit BCD payload, hundreds in the top nibble.
  typedef struct packed {
    logic [NIB_W-1:0] hundreds;
    logic [NIB_W-1:0] tens;
    logic [NIB_W-1:0] ones;
  } bcd_t;

  // Active-high patterns, bit 6 = a ... bit 0 = g.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int i = 0; i < 3; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/modulo_display_contador_7_bits_decodificador_bcd_7seg.sv
// BCD digit to active-high 7-segment pattern; non-decimal codes light nothing.
module decodificador_bcd_7seg
  import modulo_display_contador_7_bits_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_ah
);

  // Pure lookup of the decimal patterns.
  always_comb begin
    seg_ah = SEG_BLANK;
    case (nib)
      4'd0:    seg_ah = SEG_0;
      4'd1:    seg_ah = SEG_1;
      4'd2:    seg_ah = SEG_2;
      4'd3:    seg_ah = SEG_3;
      4'd4:    seg_ah = SEG_4;
      4'd5:    seg_ah = SEG_5;
      4'd6:    seg_ah = SEG_6;
      4'd7:    seg_ah = SEG_7;
      4'd8:    seg_ah = SEG_8;
      4'd9:    seg_ah = SEG_9;
      default: seg_ah = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/modulo_display_contador_7_bits.sv
// Binary count -> BCD (sequential shift-add-3) -> multiplexed 3-digit 7-segment display.
module modulo_display_contador_7_bits
  import modulo_display_contador_7_bits_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 16,
  parameter bit          COMMON_ANODE = 1'b1,
  parameter bit          BLANK_ZEROS  = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [6:0]  q,
  output logic [11:0] bcd_out,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [2:0]  dig
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SEG_W-1:0] SEG_RESET = COMMON_ANODE ? ~SEG_0 : SEG_0;

  conv_state_t          state;
  logic [BIN_W-1:0]     shift_reg;
  logic [BCD_W-1:0]     acc;
  logic [BIT_CNT_W-1:0] bit_cnt;
  bcd_t                 bcd_q;

  logic [BCD_W-1:0]         acc_adj;
  logic [BCD_W+BIN_W-1:0]   shifted;

  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] dig_idx;

  logic [NIB_W-1:0] nib_sel;
  logic             blank;
  logic [SEG_W-1:0] seg_ah;
  logic [SEG_W-1:0] seg_next;
  logic [DIG_N-1:0] dig_next;

  // One double-dabble step: correct nibbles, then shift {acc, shift_reg} left.
  always_comb begin
    acc_adj = add3_nibbles(acc);
    shifted = {acc_adj, shift_reg} << 1;
  end

  // Conversion FSM: capture in IDLE, 7 shift steps in CONV, publish in LOAD.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      shift_reg <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      bcd_q     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          shift_reg <= q;
          acc       <= '0;
          bit_cnt   <= '0;
          busy      <= 1'b1;
          state     <= CONV;
        end
        CONV: begin
          acc       <= shifted[BCD_W+BIN_W-1:BIN_W];
          shift_reg <= shifted[BIN_W-1:0];
          bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
          busy      <= 1'b1;
          if (bit_cnt == BIT_CNT_W'(BIN_W - 1)) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          bcd_q <= bcd_t'(acc);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bcd_out = bcd_q;

  // Free-running scan divider and digit index, independent of conversions.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      dig_idx <= (dig_idx == IDX_W'(DIG_N - 1)) ? '0 : dig_idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Select the digit nibble for the current index and decide leading-zero blanking.
  always_comb begin
    nib_sel = bcd_q.ones;
    blank   = 1'b0;
    case (dig_idx)
      2'd1: begin
        nib_sel = bcd_q.tens;
        blank   = BLANK_ZEROS && (bcd_q.hundreds == 4'd0) && (bcd_q.tens == 4'd0);
      end
      2'd2: begin
        nib_sel = bcd_q.hundreds;
        blank   = BLANK_ZEROS && (bcd_q.hundreds == 4'd0);
      end
      default: begin
        nib_sel = bcd_q.ones;
        blank   = 1'b0;
      end
    endcase
  end

  decodificador_bcd_7seg u_dec (
    .nib    (nib_sel),
    .seg_ah (seg_ah)
  );

  // Apply blanking and panel polarity; digit selects are always active-low.
  always_comb begin
    seg_next = blank ? SEG_BLANK : seg_ah;
    if (COMMON_ANODE) begin
      seg_next = ~seg_next;
    end
    dig_next = ~(DIG_N'(1) << dig_idx);
  end

  // Segments and digit select register together so digits never ghost.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      seg <= SEG_RESET;
      dig <= 3'b110;
    end else begin
      seg <= seg_next;
      dig <= dig_next;
    end
  end

endmodule

// File: tb/tb_modulo_display_contador_7_bits.sv
// Randomised bench with a behavioural display model; two DUT configurations share stimulus.
module tb_modulo_display_contador_7_bits;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [6:0]  q   = 7'd0;

  logic [11:0] bcd_a, bcd_b;
  logic        busy_a, busy_b;
  logic [6:0]  seg_a, seg_b;
  logic [2:0]  dig_a, dig_b;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  modulo_display_contador_7_bits #(
    .SCAN_DIV(4), .COMMON_ANODE(1'b1), .BLANK_ZEROS(1'b1)
  ) dut_a (
    .clk(clk), .clr(clr), .q(q),
    .bcd_out(bcd_a), .busy(busy_a), .seg(seg_a), .dig(dig_a)
  );

  modulo_display_contador_7_bits #(
    .SCAN_DIV(5), .COMMON_ANODE(1'b0), .BLANK_ZEROS(1'b0)
  ) dut_b (
    .clk(clk), .clr(clr), .q(q),
    .bcd_out(bcd_b), .busy(busy_b), .seg(seg_b), .dig(dig_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference patterns, a..g with a as the MSB, active-high.
  function automatic logic [6:0] digit_pat(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [6:0] seg_ref(input int idx, input int val, input bit ca, input bit bz);
    int h, t, o, d;
    bit blank;
    logic [6:0] s;
    h = val / 100;
    t = (val / 10) % 10;
    o = val % 10;
    d = (idx == 0) ? o : (idx == 1) ? t : h;
    blank = bz && ((idx == 2 && h == 0) || (idx == 1 && h == 0 && t == 0));
    s = blank ? 7'b0000000 : digit_pat(d);
    return ca ? ~s : s;
  endfunction

  // Model: k counts rising edges since reset release; a conversion spans 9 edges.
  int         k;
  int         m_val;
  logic [6:0] cap;
  bit         m_busy;
  logic [6:0] m_seg_a, m_seg_b;
  logic [2:0] m_dig_a, m_dig_b;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      k       = 0;
      m_val   = 0;
      m_busy  = 1'b0;
      cap     = 7'd0;
      m_seg_a = seg_ref(0, 0, 1'b1, 1'b1);
      m_seg_b = seg_ref(0, 0, 1'b0, 1'b0);
      m_dig_a = 3'b110;
      m_dig_b = 3'b110;
    end else begin
      int ia, ib;
      ia = (k / 4) % 3;
      ib = (k / 5) % 3;
      m_seg_a = seg_ref(ia, m_val, 1'b1, 1'b1);
      m_seg_b = seg_ref(ib, m_val, 1'b0, 1'b0);
      m_dig_a = ~(3'b001 << ia);
      m_dig_b = ~(3'b001 << ib);
      k = k + 1;
      if (k % 9 == 1) begin
        cap    = q;
        m_busy = 1'b1;
      end else if (k % 9 == 0) begin
        m_val  = int'(cap);
        m_busy = 1'b0;
      end else begin
        m_busy = 1'b1;
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    chk("bcd_a",  32'(bcd_a),  32'(to_bcd(m_val)));
    chk("busy_a", 32'(busy_a), 32'(m_busy));
    chk("seg_a",  32'(seg_a),  32'(m_seg_a));
    chk("dig_a",  32'(dig_a),  32'(m_dig_a));
    chk("bcd_b",  32'(bcd_b),  32'(to_bcd(m_val)));
    chk("busy_b", 32'(busy_b), 32'(m_busy));
    chk("seg_b",  32'(seg_b),  32'(m_seg_b));
    chk("dig_b",  32'(dig_b),  32'(m_dig_b));
  end

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((k % 9 != ph) && (n < 30));
    chk("wait_phase", 32'(k % 9), 32'(ph));
  endtask

  task automatic random_run(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) q = 7'($urandom_range(0, 127));
    end
  endtask

  initial begin
    // Reset state, then first conversion of 99.
    q   = 7'd99;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg_a", 32'(seg_a), 32'(7'b0000001));
    chk("rst_dig_a", 32'(dig_a), 32'(3'b110));
    chk("rst_bcd_a", 32'(bcd_a), 32'(12'h000));
    chk("rst_busy_a", 32'(busy_a), 32'(1'b0));
    chk("rst_seg_b", 32'(seg_b), 32'(7'b1111110));
    clr = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("t1_busy_before_load", 32'(busy_a), 32'(1'b1));
    chk("t1_bcd_before_load", 32'(bcd_a), 32'(12'h000));
    @(posedge clk);
    #1;
    chk("t1_bcd_99", 32'(bcd_a), 32'(12'h099));
    chk("t1_busy_after_load", 32'(busy_a), 32'(1'b0));

    // Maximum value.
    @(negedge clk);
    q = 7'd127;
    repeat (30) @(negedge clk);
    chk("t2_bcd_127", 32'(bcd_a), 32'(12'h127));

    // Blanking: single digit, then a zero tens digit that must stay lit.
    q = 7'd5;
    repeat (30) @(negedge clk);
    chk("t3_bcd_5", 32'(bcd_a), 32'(12'h005));
    q = 7'd100;
    repeat (30) @(negedge clk);

    // Input changes mid-conversion are ignored until the next capture.
    wait_phase(1);
    repeat (2) @(negedge clk);
    q = 7'd42;
    repeat (6) @(negedge clk);
    chk("t4_bcd_100", 32'(bcd_a), 32'(12'h100));
    repeat (9) @(negedge clk);
    chk("t4_bcd_042", 32'(bcd_a), 32'(12'h042));

    random_run(300);

    // Asynchronous reset in the middle of a conversion.
    q = 7'd77;
    wait_phase(3);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    chk("t6_bcd_a", 32'(bcd_a), 32'(12'h000));
    chk("t6_busy_a", 32'(busy_a), 32'(1'b0));
    chk("t6_seg_a", 32'(seg_a), 32'(7'b0000001));
    chk("t6_dig_a", 32'(dig_a), 32'(3'b110));
    chk("t6_seg_b", 32'(seg_b), 32'(7'b1111110));
    chk("t6_dig_b", 32'(dig_b), 32'(3'b110));
    @(negedge clk);
    clr = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("t6_bcd_77", 32'(bcd_a), 32'(12'h077));

    random_run(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
